posit_decode_seq: RTL and testbench

POSIT_DECODE_SEQ -- requirements
Module: posit_decode_seq

---
 rtl/posit_decode_seq.sv | 123 ++++++++++++
 tb/tb_posit_decode_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/posit_decode_seq.sv
// Sequential posit decoder: captures one posit word, scans the regime run one bit per
// cycle, then extracts the sign, regime value k, exponent and hidden-one mantissa.
module posit_decode_seq #(
  parameter int N  = 8,
  parameter int es = 2,
  parameter int Bs = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  in,
  output logic          busy,
  output logic          done,
  output logic          sign,
  output logic [Bs:0]   regime,
  output logic [es-1:0] exp,
  output logic [N-1:0]  mant,
  output logic          zero,
  output logic          inf
);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, EXTRACT, DONE} state_t;

  localparam logic [Bs-1:0] CNT_MAX = Bs'(N - 1);

  state_t         state, state_next;
  logic [N-2:0]   word;     // low bits suffice: two's complement of the low bits ignores the MSB
  logic           sign_q;
  logic [N-2:0]   sr;
  logic           rb;
  logic [Bs-1:0]  cnt;

  logic           accept, special, is_zero, is_nar, scan_go;
  logic [N-2:0]   abs_low, field;
  logic [Bs:0]    k_ext, regime_next;
  logic [es-1:0]  exp_next;
  logic [N-1:0]   mant_next;

  assign accept  = start && (state == IDLE || state == DONE);
  assign is_zero = (in == '0);
  assign is_nar  = (in == {1'b1, {(N-1){1'b0}}});
  assign special = is_zero || is_nar;
  assign scan_go = (cnt < CNT_MAX) && (sr[N-2] == rb);
  assign abs_low = sign_q ? (~word + (N-1)'(1)) : word;

  // After the scan, cnt equals the run length k; drop the terminator unless the run filled the word.
  assign field       = (cnt < CNT_MAX) ? {sr[N-3:0], 1'b0} : sr;
  assign k_ext       = {1'b0, cnt};
  assign regime_next = rb ? (k_ext - (Bs+1)'(1)) : (-k_ext);
  assign exp_next    = field[N-2 -: es];
  assign mant_next   = {1'b1, field[N-2-es:0], {es{1'b0}}};

  assign busy = (state == LOAD) || (state == SCAN) || (state == EXTRACT);
  assign done = (state == DONE);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = special ? DONE : LOAD;
      LOAD:    state_next = SCAN;
      SCAN:    if (!scan_go) state_next = EXTRACT;
      EXTRACT: state_next = DONE;
      DONE:    state_next = accept ? (special ? DONE : LOAD) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      word   <= '0;
      sign_q <= 1'b0;
      sr     <= '0;
      rb     <= 1'b0;
      cnt    <= '0;
      sign   <= 1'b0;
      regime <= '0;
      exp    <= '0;
      mant   <= '0;
      zero   <= 1'b0;
      inf    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        word   <= in[N-2:0];
        sign_q <= in[N-1];
        if (special) begin
          sign   <= in[N-1];
          zero   <= is_zero;
          inf    <= is_nar;
          regime <= '0;
          exp    <= '0;
          mant   <= '0;
        end
      end
      unique case (state)
        LOAD: begin
          sr  <= abs_low;
          rb  <= abs_low[N-2];
          cnt <= '0;
        end
        SCAN: begin
          if (scan_go) begin
            sr  <= {sr[N-3:0], 1'b0};
            cnt <= cnt + Bs'(1);
          end
        end
        EXTRACT: begin
          sign   <= sign_q;
          zero   <= 1'b0;
          inf    <= 1'b0;
          regime <= regime_next;
          exp    <= exp_next;
          mant   <= mant_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_decode_seq.sv
// Directed bench for posit_decode_seq (N=8, es=2): table of hand-decoded words plus
// sequences for start-during-scan, reset-during-scan and first-edge acceptance.
module tb_posit_decode_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_w;
  logic       busy, done, sign, zero, inf;
  logic [3:0] regime;
  logic [1:0] exp;
  logic [7:0] mant;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic [7:0] w;
    logic       sgn;
    logic [3:0] k;
    logic [1:0] ex;
    logic [7:0] mt;
    logic       zr;
    logic       nr;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  posit_decode_seq #(.N(8), .es(2), .Bs(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_w), .busy(busy), .done(done),
    .sign(sign), .regime(regime), .exp(exp), .mant(mant), .zero(zero), .inf(inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Accept one word, wait (bounded) for done, check latency and fields; optionally pulse
  // start with another word in cycle glitch_cyc, which must be ignored.
  task automatic run_vec(input vec_t v, input int glitch_cyc, input logic [7:0] glitch_w);
    int cyc = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    in_w  = v.w;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) in_w = glitch_w;
      if (cyc == 1) check($sformatf("busy_c1_%b", v.w), busy, v.lat > 1);
      if (busy && done) check("busy_done_excl", 1, 0);
      if (done) seen = 1;
    end
    start = 1'b0;
    check($sformatf("latency_%b", v.w), cyc, v.lat);
    check($sformatf("sign_%b", v.w), sign, v.sgn);
    check($sformatf("regime_%b", v.w), regime, v.k);
    check($sformatf("exp_%b", v.w), exp, v.ex);
    check($sformatf("mant_%b", v.w), mant, v.mt);
    check($sformatf("zero_%b", v.w), zero, v.zr);
    check($sformatf("inf_%b", v.w), inf, v.nr);
    @(negedge clk);
    check($sformatf("done_pulse_%b", v.w), done, 0);
    check($sformatf("mant_hold_%b", v.w), mant, v.mt);
  endtask

  initial begin
    vecs[0] = '{8'b01011010, 1'b0, 4'b0000, 2'b11, 8'b10100000, 1'b0, 1'b0, 5};
    vecs[1] = '{8'b01010000, 1'b0, 4'b0000, 2'b10, 8'b10000000, 1'b0, 1'b0, 5};
    vecs[2] = '{8'b10100110, 1'b1, 4'b0000, 2'b11, 8'b10100000, 1'b0, 1'b0, 5};
    vecs[3] = '{8'b00000001, 1'b0, 4'b1010, 2'b00, 8'b10000000, 1'b0, 1'b0, 10};
    vecs[4] = '{8'b01111111, 1'b0, 4'b0110, 2'b00, 8'b10000000, 1'b0, 1'b0, 11};
    vecs[5] = '{8'b00110000, 1'b0, 4'b1111, 2'b10, 8'b10000000, 1'b0, 1'b0, 5};
    vecs[6] = '{8'b11000001, 1'b1, 4'b1111, 2'b11, 8'b11110000, 1'b0, 1'b0, 5};
    vecs[7] = '{8'b01101101, 1'b0, 4'b0001, 2'b11, 8'b10100000, 1'b0, 1'b0, 6};
    vecs[8] = '{8'b00000000, 1'b0, 4'b0000, 2'b00, 8'b00000000, 1'b1, 1'b0, 1};
    vecs[9] = '{8'b10000000, 1'b1, 4'b0000, 2'b00, 8'b00000000, 1'b0, 1'b1, 1};

    rst_n = 1'b0;
    start = 1'b0;
    in_w  = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mant", mant, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 0, 8'h00);

    // start pulsed with a different word during the scan of 00000001
    run_vec(vecs[3], 3, 8'b01111111);

    // reset during the scan: everything clears and the abandoned word never completes
    begin
      bit seen = 0;
      @(negedge clk);
      start = 1'b1;
      in_w  = 8'b00000001;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("scan_busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_outs", {sign, regime, exp, mant, zero, inf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done || busy) seen = 1;
      end
      check("midrst_no_done", seen, 0);
    end

    // first rising edge after reset release accepts start
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    in_w  = 8'b00000000;
    @(negedge clk);
    start = 1'b0;
    check("first_edge_done", done, 1);
    check("first_edge_zero", zero, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
